imem_pipe: RTL and testbench
============================

IMEM_PIPE -- requirements
Module: imem_pipe

Interface
REQ-001 Parameters SHALL be (one per line: name, default, meaning):
  DEPTH  256  storage words; power of two.
  LIMIT  128  words fetchable; words at index LIMIT and above return HALT_INSN; 1 <= LIMIT <= DEPTH.
  LATENCY  1  request-to-response pipeline stages; legal values 1 or 2.
  HALT_INSN  32'h00000063  substitute word (beq x0,x0,0).
  INIT_FILE  "./mem/imem.hex"  $readmemh image loaded at time 0 if the file opens; otherwise contents are undefined.
REQ-002 Ports SHALL be (one per line: name direction width meaning):
  clk  in  1  single clock; all state changes on its rising edge.
  rst_n  in  1  asynchronous, active-low reset.
  req_valid  in  1  fetch request present.
  req_ready  out  1  request accepted this cycle when both valid and ready are high.
  req_addr  in  32  byte address of the fetch.
  rsp_valid  out  1  response present.
  rsp_ready  in  1  consumer accepts the response.
  rsp_instr  out  32  fetched instruction word.
  rsp_err  out  1  misaligned fetch flag.
  prog_we  in  1  program-load write strobe.
  prog_addr  in  32  program-load byte address.
  prog_wdata  in  32  program-load data.
  fetch_cnt  out  32  count of accepted requests.

Function
REQ-003 Word index SHALL be req_addr[31:2]; the full 30-bit index is compared, so upper address bits never alias.
REQ-004 In the accept cycle, index < LIMIT SHALL read memory[index]; index >= LIMIT SHALL yield HALT_INSN.
REQ-005 req_addr[1:0] != 0 SHALL yield rsp_instr = HALT_INSN and rsp_err = 1; otherwise rsp_err = 0.
REQ-006 Memory SHALL be read in the accept cycle; the word travels through LATENCY valid-tagged stages, and the last stage drives rsp_*.
REQ-007 With no backpressure, the response to a request accepted in cycle N SHALL appear with rsp_valid = 1 in cycle N+LATENCY.
REQ-008 Stall SHALL be rsp_valid & ~rsp_ready; on stall, every stage holds and rsp_instr/rsp_err stay stable.
REQ-009 A bubble stage SHALL be filled even while the output stalls (for LATENCY=2 the first stage loads when empty).
REQ-010 req_ready SHALL be ~prog_we & (first stage empty | first stage advancing this cycle).
REQ-011 Sustained throughput SHALL be one response per cycle when rsp_ready stays 1.
REQ-012 Responses SHALL leave in request order, with none lost or duplicated.
REQ-013 prog_we = 1 with prog_addr[31:2] < DEPTH SHALL write prog_wdata to memory[prog_addr[31:2]] at the clock edge.
REQ-014 Writes with an out-of-range index SHALL be ignored; prog_addr[1:0] SHALL be ignored.
REQ-015 prog_we SHALL NOT stall the pipeline; in-flight words keep their read-time (old) value.
REQ-016 A write at index >= LIMIT and < DEPTH SHALL be stored but not fetchable.
REQ-017 fetch_cnt SHALL increment by 1 per accepted request and saturate at 32'hFFFFFFFF.

Reset
REQ-018 rst_n low SHALL immediately clear all stage valids, rsp_valid, rsp_err, fetch_cnt and set rsp_instr = 32'h0, independent of clk.
REQ-019 In-flight requests at reset assertion SHALL be discarded with no response.
REQ-020 Memory contents SHALL NOT be altered by reset.
REQ-021 req_ready SHALL be 0 while rst_n is low; it SHALL equal ~prog_we from the first edge after release.

Verification
REQ-022 LATENCY=1, image word0=32'h00500093, rsp_ready=1: request addr 0 in cycle N -> cycle N+1 rsp_valid=1, rsp_instr=32'h00500093, rsp_err=0, fetch_cnt=1.
REQ-023 Requests to addr 32'h200 (index 128), 32'h1000_0000 and 32'h6 -> HALT_INSN, HALT_INSN, HALT_INSN with rsp_err = 0, 0, 1 respectively.
REQ-024 LATENCY=2, 6 back-to-back requests, rsp_ready low cycles 3-5 -> rsp_instr held stable during the stall, all 6 responses in order, none dropped, fetch_cnt=6.
REQ-025 prog_we=1, prog_addr=32'h10, prog_wdata=32'hDEADBEEF with req_valid=1 -> req_ready=0 that cycle; a later fetch of 32'h10 returns 32'hDEADBEEF; a write to 32'h400 (index 256) is ignored and memory is unchanged.
REQ-026 rst_n pulsed low mid-way through a 4-request stream -> rsp_valid=0 and fetch_cnt=0 immediately; no stale response after release; memory retains its image.

Source files
------------

// File: rtl/imem_pipe.sv
// Instruction memory with a valid/ready fetch port, a 1- or 2-stage response pipeline
// and a program-load write port. Out-of-window or misaligned fetches return HALT_INSN.
module imem_pipe #(
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned LIMIT     = 128,
  parameter int unsigned LATENCY   = 1,
  parameter logic [31:0] HALT_INSN = 32'h00000063,
  parameter string       INIT_FILE = "./mem/imem.hex"
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_instr,
  output logic        rsp_err,
  input  logic        prog_we,
  input  logic [31:0] prog_addr,
  input  logic [31:0] prog_wdata,
  output logic [31:0] fetch_cnt
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0] r_mem [DEPTH];
  logic        r_vld [LATENCY];
  logic [31:0] r_ins [LATENCY];
  logic        r_err [LATENCY];
  logic [31:0] r_cnt;

  logic [LATENCY-1:0] w_en;
  logic               w_acc;
  logic [31:0]        w_idx;
  logic [31:0]        w_pidx;
  logic               w_fetchable;
  logic               w_wr_hit;
  logic               w_ld_err;
  logic [31:0]        w_ld_ins;
  logic               w_unused;

  assign w_idx       = {2'b00, req_addr[31:2]};
  assign w_fetchable = (w_idx < LIMIT);
  assign w_ld_err    = |req_addr[1:0];

  always_comb begin
    w_ld_ins = HALT_INSN;
    if (!w_ld_err && w_fetchable) begin
      w_ld_ins = r_mem[w_idx[AW-1:0]];
    end
  end

  assign w_pidx   = {2'b00, prog_addr[31:2]};
  assign w_wr_hit = prog_we && (w_pidx < DEPTH);
  assign w_unused = ^prog_addr[1:0];

  always_ff @(posedge clk) begin
    if (w_wr_hit) begin
      r_mem[w_pidx[AW-1:0]] <= prog_wdata;
    end
  end

  // A stage may load when it is empty or when everything downstream of it moves.
  always_comb begin
    logic v_en;
    w_en = '0;
    v_en = ~r_vld[LATENCY-1] | rsp_ready;
    w_en[LATENCY-1] = v_en;
    for (int i = int'(LATENCY) - 2; i >= 0; i--) begin
      v_en    = ~r_vld[i] | v_en;
      w_en[i] = v_en;
    end
  end

  assign req_ready = rst_n & ~prog_we & w_en[0];
  assign w_acc     = req_valid & req_ready;

  for (genvar g = 0; g < LATENCY; g++) begin : g_stage
    if (g == 0) begin : g_first
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_vld[0] <= 1'b0;
          r_ins[0] <= 32'h0;
          r_err[0] <= 1'b0;
        end else if (w_en[0]) begin
          r_vld[0] <= w_acc;
          if (w_acc) begin
            r_ins[0] <= w_ld_ins;
            r_err[0] <= w_ld_err;
          end
        end
      end
    end else begin : g_next
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_vld[g] <= 1'b0;
          r_ins[g] <= 32'h0;
          r_err[g] <= 1'b0;
        end else if (w_en[g]) begin
          r_vld[g] <= r_vld[g-1];
          if (r_vld[g-1]) begin
            r_ins[g] <= r_ins[g-1];
            r_err[g] <= r_err[g-1];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 32'h0;
    end else if (w_acc && (r_cnt != 32'hFFFF_FFFF)) begin
      r_cnt <= r_cnt + 32'd1;
    end
  end

  assign rsp_valid = r_vld[LATENCY-1];
  assign rsp_instr = r_ins[LATENCY-1];
  assign rsp_err   = r_err[LATENCY-1];
  assign fetch_cnt = r_cnt;

endmodule

// File: tb/tb_imem_pipe.sv
// Bench for imem_pipe: one LATENCY=1 and one LATENCY=2 instance share the program port;
// a word-array model and in-order response queues supply every expected value.
module tb_imem_pipe;

  localparam logic [31:0] HALT = 32'h00000063;

  typedef struct {
    logic [31:0] w;
    logic        e;
    int          cyc;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid [2];
  logic [31:0] req_addr;
  logic        rsp_ready;
  logic        prog_we;
  logic [31:0] prog_addr;
  logic [31:0] prog_wdata;
  logic        req_ready [2];
  logic        rsp_valid [2];
  logic        rsp_err   [2];
  logic [31:0] rsp_instr [2];
  logic [31:0] fetch_cnt [2];

  rsp_t        exp_q[$];
  rsp_t        got_q[$];
  logic [31:0] mdl_mem [256];
  int unsigned mdl_cnt [2];
  int          lat [2] = '{1, 2};
  int          sel;
  int          cyc;
  int          total;
  int          bad;

  always #5 clk = ~clk;

  imem_pipe #(.DEPTH(256), .LIMIT(128), .LATENCY(1), .HALT_INSN(HALT)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_addr(req_addr), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready),
    .rsp_instr(rsp_instr[0]), .rsp_err(rsp_err[0]), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_wdata(prog_wdata), .fetch_cnt(fetch_cnt[0])
  );

  imem_pipe #(.DEPTH(256), .LIMIT(128), .LATENCY(2), .HALT_INSN(HALT)) u_lat2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_addr(req_addr), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready),
    .rsp_instr(rsp_instr[1]), .rsp_err(rsp_err[1]), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_wdata(prog_wdata), .fetch_cnt(fetch_cnt[1])
  );

  // What a fetch of address a must return, given the memory contents at acceptance.
  function automatic rsp_t model_rsp(input logic [31:0] a);
    rsp_t r;
    r.cyc = cyc + lat[sel];
    if (a[1:0] != 2'b00) begin
      r.w = HALT;
      r.e = 1'b1;
    end else if ({2'b00, a[31:2]} >= 32'd128) begin
      r.w = HALT;
      r.e = 1'b0;
    end else begin
      r.w = mdl_mem[a[9:2]];
      r.e = 1'b0;
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 4))
      0, 1:    a = {22'd0, 8'($urandom_range(0, 127)), 2'b00};
      2:       a = {22'd0, 8'($urandom_range(128, 255)), 2'b00};
      3:       begin a = $urandom; a[1:0] = 2'($urandom_range(1, 3)); end
      default: a = $urandom & 32'hFFFF_FFFC;
    endcase
    return a;
  endfunction

  // One clock: handshakes are observed mid-cycle, then inputs may change at edge + 1.
  task automatic step();
    rsp_t g;
    @(negedge clk);
    if (rst_n) begin
      if (req_valid[sel] && req_ready[sel]) begin
        exp_q.push_back(model_rsp(req_addr));
        mdl_cnt[sel]++;
      end
      if (rsp_valid[sel] && rsp_ready) begin
        g.w = rsp_instr[sel];
        g.e = rsp_err[sel];
        g.cyc = cyc;
        got_q.push_back(g);
      end
      if (prog_we && ({2'b00, prog_addr[31:2]} < 32'd256)) mdl_mem[prog_addr[9:2]] = prog_wdata;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic drain();
    req_valid[0] = 1'b0;
    req_valid[1] = 1'b0;
    prog_we = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 16 && got_q.size() < exp_q.size(); i++) step();
    repeat (3) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    req_valid[0] = 1'b0;
    req_valid[1] = 1'b0;
    req_addr = 32'h0;
    rsp_ready = 1'b1;
    prog_we = 1'b0;
    prog_addr = 32'h0;
    prog_wdata = 32'h0;
    #1 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      total += 4;
      if (rsp_valid[i] !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid[%0d]: got %b want 0", i, rsp_valid[i]); end
      if (rsp_err[i] !== 1'b0) begin bad++; $display("FAIL reset_rsp_err[%0d]: got %b want 0", i, rsp_err[i]); end
      if (rsp_instr[i] !== 32'h0) begin bad++; $display("FAIL reset_rsp_instr[%0d]: got %h want 0", i, rsp_instr[i]); end
      if (req_ready[i] !== 1'b0) begin bad++; $display("FAIL reset_req_ready[%0d]: got %b want 0", i, req_ready[i]); end
      total++;
      if (fetch_cnt[i] !== 32'h0) begin bad++; $display("FAIL reset_fetch_cnt[%0d]: got %0d want 0", i, fetch_cnt[i]); end
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    for (int i = 0; i < 2; i++) begin
      total++;
      if (req_ready[i] !== 1'b1) begin bad++; $display("FAIL release_req_ready[%0d]: got %b want 1", i, req_ready[i]); end
    end
  endtask

  task automatic test_preload();
    for (int i = 0; i < 256; i++) begin
      prog_we = 1'b1;
      prog_addr = {22'd0, 8'(i), 2'($urandom_range(0, 3))};
      prog_wdata = (i == 0) ? 32'h00500093 : $urandom;
      step();
    end
    prog_we = 1'b0;
  endtask

  task automatic test_basic();
    sel = 0;
    exp_q.delete();
    got_q.delete();
    req_valid[0] = 1'b1;
    req_addr = 32'h0;
    rsp_ready = 1'b1;
    step();
    req_valid[0] = 1'b0;
    total += 4;
    if (rsp_valid[0] !== 1'b1) begin bad++; $display("FAIL basic_valid: got %b want 1", rsp_valid[0]); end
    if (rsp_instr[0] !== 32'h00500093) begin bad++; $display("FAIL basic_instr: got %h want 00500093", rsp_instr[0]); end
    if (rsp_err[0] !== 1'b0) begin bad++; $display("FAIL basic_err: got %b want 0", rsp_err[0]); end
    if (fetch_cnt[0] !== 32'd1) begin bad++; $display("FAIL basic_cnt: got %0d want 1", fetch_cnt[0]); end
    drain();
  endtask

  task automatic test_halt();
    logic [31:0] addrs [3];
    addrs = '{32'h0000_0200, 32'h1000_0000, 32'h0000_0006};
    sel = 0;
    exp_q.delete();
    got_q.delete();
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_valid[0] = 1'b1;
      req_addr = addrs[i];
      step();
    end
    drain();
    total++;
    if (got_q.size() != 3) begin bad++; $display("FAIL halt_count: got %0d want 3", got_q.size()); end
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      total++;
      if (got_q[i].w !== HALT || got_q[i].e !== (i == 2) || got_q[i].cyc != exp_q[i].cyc) begin
        bad++;
        $display("FAIL halt[%0d]: got instr=%h err=%b cyc=%0d want instr=%h err=%b cyc=%0d", i,
                 got_q[i].w, got_q[i].e, got_q[i].cyc, HALT, (i == 2), exp_q[i].cyc);
      end
    end
  endtask

  task automatic test_prog();
    sel = 0;
    exp_q.delete();
    got_q.delete();
    req_valid[0] = 1'b1;
    req_addr = 32'h10;
    prog_we = 1'b1;
    prog_addr = 32'h10;
    prog_wdata = 32'hDEADBEEF;
    #1;
    total++;
    if (req_ready[0] !== 1'b0) begin bad++; $display("FAIL prog_blocks_req: got %b want 0", req_ready[0]); end
    step();
    prog_addr = 32'h400;
    prog_wdata = 32'h1234_5678;
    step();
    prog_we = 1'b0;
    step();
    req_addr = 32'h0;
    step();
    drain();
    total++;
    if (got_q.size() != 2) begin bad++; $display("FAIL prog_count: got %0d want 2", got_q.size()); end
    if (got_q.size() == 2) begin
      total += 2;
      if (got_q[0].w !== 32'hDEADBEEF) begin bad++; $display("FAIL prog_readback: got %h want deadbeef", got_q[0].w); end
      if (got_q[1].w !== 32'h00500093) begin bad++; $display("FAIL prog_oob_ignored: got %h want 00500093", got_q[1].w); end
    end
  endtask

  task automatic test_stall();
    logic [31:0] held;
    bit          stalled;
    int          n_stall;
    sel = 1;
    exp_q.delete();
    got_q.delete();
    n_stall = 0;
    for (int c = 0; c < 30 && got_q.size() < 6; c++) begin
      req_valid[1] = (exp_q.size() < 6);
      req_addr = {22'd0, 8'($urandom_range(0, 127)), 2'b00};
      rsp_ready = !(c >= 3 && c <= 5);
      stalled = rsp_valid[1] && !rsp_ready;
      held = rsp_instr[1];
      step();
      if (stalled) begin
        n_stall++;
        total++;
        if (rsp_valid[1] !== 1'b1 || rsp_instr[1] !== held) begin
          bad++;
          $display("FAIL stall_hold c=%0d: got valid=%b instr=%h want valid=1 instr=%h", c,
                   rsp_valid[1], rsp_instr[1], held);
        end
      end
    end
    drain();
    total += 3;
    if (n_stall != 3) begin bad++; $display("FAIL stall_cycles: got %0d want 3", n_stall); end
    if (got_q.size() != 6) begin bad++; $display("FAIL stall_count: got %0d want 6", got_q.size()); end
    if (fetch_cnt[1] !== 32'd6) begin bad++; $display("FAIL stall_cnt: got %0d want 6", fetch_cnt[1]); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i].w !== exp_q[i].w || got_q[i].e !== exp_q[i].e) begin
        bad++;
        $display("FAIL stall_order[%0d]: got %h/%b want %h/%b", i, got_q[i].w, got_q[i].e,
                 exp_q[i].w, exp_q[i].e);
      end
    end
  endtask

  task automatic test_random(input int s);
    sel = s;
    exp_q.delete();
    got_q.delete();
    for (int c = 0; c < 400 && exp_q.size() < 60; c++) begin
      req_valid[s] = ($urandom_range(0, 3) != 0);
      req_addr = rand_addr();
      rsp_ready = ($urandom_range(0, 3) != 0);
      prog_we = ($urandom_range(0, 7) == 0);
      prog_addr = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_03FF);
      prog_wdata = $urandom;
      step();
    end
    drain();
    total += 2;
    if (got_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL rand%0d_count: got %0d want %0d", s, got_q.size(), exp_q.size());
    end
    if (fetch_cnt[s] !== mdl_cnt[s]) begin
      bad++;
      $display("FAIL rand%0d_cnt: got %0d want %0d", s, fetch_cnt[s], mdl_cnt[s]);
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i].w !== exp_q[i].w || got_q[i].e !== exp_q[i].e) begin
        bad++;
        $display("FAIL rand%0d[%0d]: got %h/%b want %h/%b", s, i, got_q[i].w, got_q[i].e,
                 exp_q[i].w, exp_q[i].e);
      end
    end
  endtask

  task automatic test_reset_mid();
    sel = 1;
    exp_q.delete();
    got_q.delete();
    rsp_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_valid[1] = 1'b1;
      req_addr = {22'd0, 8'(i), 2'b00};
      step();
    end
    #2 rst_n = 1'b0;
    #1;
    total += 4;
    if (rsp_valid[1] !== 1'b0) begin bad++; $display("FAIL mid_rsp_valid: got %b want 0", rsp_valid[1]); end
    if (fetch_cnt[1] !== 32'h0) begin bad++; $display("FAIL mid_cnt1: got %0d want 0", fetch_cnt[1]); end
    if (fetch_cnt[0] !== 32'h0) begin bad++; $display("FAIL mid_cnt0: got %0d want 0", fetch_cnt[0]); end
    if (req_ready[1] !== 1'b0) begin bad++; $display("FAIL mid_req_ready: got %b want 0", req_ready[1]); end
    exp_q.delete();
    got_q.delete();
    mdl_cnt[0] = 0;
    mdl_cnt[1] = 0;
    req_valid[1] = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) step();
    total += 2;
    if (got_q.size() != 0) begin bad++; $display("FAIL mid_stale: got %0d responses want 0", got_q.size()); end
    if (req_ready[1] !== 1'b1) begin bad++; $display("FAIL mid_release_ready: got %b want 1", req_ready[1]); end
    for (int c = 0; c < 20 && exp_q.size() < 4; c++) begin
      req_valid[1] = 1'b1;
      req_addr = {22'd0, 8'($urandom_range(0, 127)), 2'b00};
      step();
    end
    drain();
    total += 2;
    if (got_q.size() != 4) begin bad++; $display("FAIL mid_count: got %0d want 4", got_q.size()); end
    if (fetch_cnt[1] !== 32'd4) begin bad++; $display("FAIL mid_cnt_after: got %0d want 4", fetch_cnt[1]); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i].w !== exp_q[i].w || got_q[i].e !== exp_q[i].e) begin
        bad++;
        $display("FAIL mid_image[%0d]: got %h/%b want %h/%b", i, got_q[i].w, got_q[i].e,
                 exp_q[i].w, exp_q[i].e);
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    cyc = 0;
    sel = 0;
    mdl_cnt[0] = 0;
    mdl_cnt[1] = 0;
    test_reset();
    test_preload();
    test_basic();
    test_halt();
    test_prog();
    test_stall();
    test_random(0);
    test_random(1);
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
